// File: rtl/mdu_pkg.sv
// MDU shared definitions: op encodings, default latencies, HI/LO payload type
// and the helper that sizes the busy down-counter.
package mdu_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned OP_W            = 4;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // Counter wide enough for the longer latency, never narrower than 4 bits.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, reset (async active-low)
//   A, B        : E-stage operands (rs, rt)
//   MDUop       : E-stage operation (mdu_op_e encoding)
//   req         : flush of the current E instruction, kills its side effects
//   start       : comb, an arithmetic op is being accepted this cycle
//   busy        : registered, an operation is in flight
//   HI, LO      : architectural registers
//   out         : comb, HI on mfhi, LO on mflo, else 0
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [OP_W-1:0] MDUop,
  input  logic            req,
  output logic            start,
  output logic            busy,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO,
  output logic [XLEN-1:0] out
);

  localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]  hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

  logic                   is_mul, is_div, b_zero, div_ovf;
  logic signed [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0]      prod_u;
  logic [XLEN-1:0]        div_s_b, div_u_b;
  logic [XLEN-1:0]        quot_s, rem_s, quot_u, rem_u;

  assign is_mul = (MDUop == MDU_MULT) || (MDUop == MDU_MULTU);
  assign is_div = (MDUop == MDU_DIV)  || (MDUop == MDU_DIVU);
  assign b_zero = (B == '0);
  assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  // Arithmetic datapath
  assign prod_s = $signed({{XLEN{A[XLEN-1]}}, A}) * $signed({{XLEN{B[XLEN-1]}}, B});
  assign prod_u = {{XLEN{1'b0}}, A} * {{XLEN{1'b0}}, B};

  // Substitute divisor 1 for /0 (result discarded) and for MIN/-1, where
  // dividing by 1 yields exactly the required quotient MIN, remainder 0.
  assign div_s_b = (b_zero || div_ovf) ? XLEN'(1) : B;
  assign div_u_b = b_zero ? XLEN'(1) : B;
  assign quot_s  = $signed(A) / $signed(div_s_b);
  assign rem_s   = $signed(A) % $signed(div_s_b);
  assign quot_u  = A / div_u_b;
  assign rem_u   = A % div_u_b;

  assign start = (is_mul || is_div) && !req && (state_q == ST_IDLE);
  assign busy  = (state_q == ST_BUSY);
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign out   = (MDUop == MDU_MFHI) ? hi_q :
                 (MDUop == MDU_MFLO) ? lo_q : '0;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          cnt_d   = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          case (MDUop)
            MDU_MULT:  {hi_tmp_d, lo_tmp_d} = prod_s;
            MDU_MULTU: {hi_tmp_d, lo_tmp_d} = prod_u;
            MDU_DIV: begin
              // Divide by zero commits the current HI/LO, i.e. no change
              hi_tmp_d = b_zero ? hi_q : rem_s;
              lo_tmp_d = b_zero ? lo_q : quot_s;
            end
            default: begin
              hi_tmp_d = b_zero ? hi_q : rem_u;
              lo_tmp_d = b_zero ? lo_q : quot_u;
            end
          endcase
        end else if (!req) begin
          if (MDUop == MDU_MTHI) hi_d = A;
          if (MDUop == MDU_MTLO) lo_d = A;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = hi_tmp_q;
          lo_d    = lo_tmp_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: expected HI/LO queued at issue, compared at completion.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDUop;
  logic        req;
  logic        start, busy;
  logic [31:0] HI, LO, out;

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUop(MDUop), .req(req),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .out(out)
  );

  int    checks = 0;
  int    errors = 0;
  hilo_t sb_q[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model built on 64-bit integer arithmetic.
  function automatic hilo_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    hilo_t r;
    longint sa, sb, q, rm, p;
    longint unsigned ua, ub, pu;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    r.hi = cur_hi;
    r.lo = cur_lo;
    if (op == MDU_MULT) begin
      p = sa * sb;
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (op == MDU_MULTU) begin
      pu = ua * ub;
      r.hi = pu[63:32];
      r.lo = pu[31:0];
    end else if (b != 32'd0) begin
      if (op == MDU_DIV) begin
        q = sa / sb;
        rm = sa % sb;
      end else begin
        q = longint'(ua / ub);
        rm = longint'(ua % ub);
      end
      r.hi = rm[31:0];
      r.lo = q[31:0];
    end
    return r;
  endfunction

  // Issue one arithmetic op, measure busy length, compare result and mfhi/mflo.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input hilo_t exp, input int n);
    int    cnt;
    hilo_t e;
    cnt = 0;
    MDUop = op; A = a; B = b; req = 1'b0;
    #1;
    chk({tag, " start"}, {31'b0, start}, 32'd1);
    sb_q.push_back(exp);
    tick();
    MDUop = MDU_NONE; A = '0; B = '0;
    while (busy === 1'b1 && cnt < n + 4) begin
      cnt++;
      tick();
    end
    chk({tag, " busy_cycles"}, 32'(cnt), 32'(n));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, " HI"}, HI, e.hi);
      chk({tag, " LO"}, LO, e.lo);
      hi_m = e.hi;
      lo_m = e.lo;
    end
    MDUop = MDU_MFHI;
    #1;
    chk({tag, " mfhi"}, out, hi_m);
    MDUop = MDU_MFLO;
    #1;
    chk({tag, " mflo"}, out, lo_m);
    MDUop = MDU_NONE;
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          cnt;
    hilo_t       e;

    A = '0; B = '0; MDUop = MDU_NONE; req = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    MDUop = MDU_MFHI;
    #1;
    chk("reset mfhi", out, 32'd0);
    MDUop = MDU_NONE;
    reset = 1'b1;

    // First edge after release accepts the op
    issue("mult", MDU_MULT, 32'hFFFF_FFFF, 32'h2, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFE}, 5);
    issue("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'h2, '{hi: 32'h0000_0001, lo: 32'hFFFF_FFFE}, 5);
    issue("div", MDU_DIV, 32'hFFFF_FFF9, 32'h2, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD}, 10);
    issue("divu0", MDU_DIVU, 32'h7, 32'h0, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD}, 10);
    issue("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '{hi: 32'h0, lo: 32'h8000_0000}, 10);
    issue("divu", MDU_DIVU, 32'd100, 32'd7, '{hi: 32'd2, lo: 32'd14}, 10);
    issue("div_neg_divisor", MDU_DIV, 32'd7, 32'hFFFF_FFFE, '{hi: 32'd1, lo: 32'hFFFF_FFFD}, 10);

    for (int i = 0; i < 6; i++) begin
      rop = 4'(1 + $urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 5) ? 32'd0 : $urandom;
      issue("rand", rop, ra, rb, model(rop, ra, rb, hi_m, lo_m),
            (rop == MDU_MULT || rop == MDU_MULTU) ? 5 : 10);
    end

    // Flushed mult: no start, no busy, no change
    MDUop = MDU_MULT; A = 32'd3; B = 32'd4; req = 1'b1;
    #1;
    chk("req start", {31'b0, start}, 32'd0);
    tick();
    chk("req busy", {31'b0, busy}, 32'd0);
    chk("req HI", HI, hi_m);
    chk("req LO", LO, lo_m);

    // mthi/mtlo gated by req
    MDUop = MDU_MTHI; A = 32'h1234_5678; req = 1'b1;
    #1;
    chk("mthi start", {31'b0, start}, 32'd0);
    tick();
    chk("mthi req HI", HI, hi_m);
    req = 1'b0;
    tick();
    chk("mthi HI", HI, 32'h1234_5678);
    chk("mthi busy", {31'b0, busy}, 32'd0);
    hi_m = 32'h1234_5678;
    MDUop = MDU_MTLO; A = 32'hCAFE_F00D;
    tick();
    chk("mtlo LO", LO, 32'hCAFE_F00D);
    chk("mtlo HI", HI, hi_m);
    lo_m = 32'hCAFE_F00D;
    MDUop = MDU_NONE;

    // Ops and flush while busy are ignored; the in-flight op completes
    MDUop = MDU_MULTU; A = 32'h0001_0000; B = 32'h0001_0000;
    #1;
    chk("busy_ign start", {31'b0, start}, 32'd1);
    sb_q.push_back('{hi: 32'h1, lo: 32'h0});
    tick();
    cnt = 0;
    while (busy === 1'b1 && cnt < 9) begin
      cnt++;
      MDUop = (cnt % 2 == 1) ? MDU_MTHI : MDU_DIV;
      A = 32'hDEAD_BEEF; B = 32'd1;
      req = (cnt == 2);
      #1;
      chk("busy_ign start_low", {31'b0, start}, 32'd0);
      tick();
    end
    MDUop = MDU_NONE; req = 1'b0;
    chk("busy_ign cycles", 32'(cnt), 32'd5);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("busy_ign HI", HI, e.hi);
      chk("busy_ign LO", LO, e.lo);
    end

    // Reset in the middle of a divide
    MDUop = MDU_DIV; A = 32'd100; B = 32'd3;
    #1;
    tick();
    MDUop = MDU_NONE;
    chk("rst_mid busy_before", {31'b0, busy}, 32'd1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mid busy", {31'b0, busy}, 32'd0);
    chk("rst_mid HI", HI, 32'd0);
    chk("rst_mid LO", LO, 32'd0);
    tick();
    reset = 1'b1;
    MDUop = MDU_MFLO;
    #1;
    chk("rst_mid mflo", out, 32'd0);
    repeat (12) tick();
    chk("rst_mid late busy", {31'b0, busy}, 32'd0);
    chk("rst_mid late LO", LO, 32'd0);
    chk("rst_mid late HI", HI, 32'd0);
    MDUop = MDU_NONE;

    chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of mult/multu in cycles.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of div/divu in cycles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 A  input  32  operand rs (forwarded value, E stage).
REQ-006 B  input  32  operand rt (forwarded value, E stage).
REQ-007 MDUop  input  4  E-stage op: none, mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
REQ-008 req  input  1  exception/interrupt flush of current E instruction; suppresses all MDU side effects this cycle.
REQ-009 start  output  1  combinational; op is mult/multu/div/divu, req low, busy low; feeds stall unit as E_MDUstart.
REQ-010 busy  output  1  registered; high while an operation is in flight; feeds stall unit as E_MDUbusy.
REQ-011 HI  output  32  architectural HI register.
REQ-012 LO  output  32  architectural LO register.
REQ-013 out  output  32  combinational: HI when mfhi, LO when mflo, else 0.

Function
REQ-014 Two states: IDLE (busy=0) and BUSY (busy=1), plus down-counter cnt, 4 bits minimum.
REQ-015 IDLE + start: edge latches computed result into internal hi_tmp/lo_tmp, loads cnt with MULT_CYCLES or DIV_CYCLES, enters BUSY.
REQ-016 BUSY: cnt decrements each edge; when cnt==1, edge copies hi_tmp/lo_tmp into HI/LO and returns to IDLE.
REQ-017 Timing: start in cycle T -> busy high cycles T+1..T+N, new HI/LO visible cycle T+N+1 together with busy=0.
REQ-018 mult: signed 64-bit product of A,B; HI=upper 32, LO=lower 32.
REQ-019 multu: unsigned 64-bit product; same split.
REQ-020 div: signed; LO=quotient truncated toward zero, HI=remainder with sign of dividend.
REQ-021 divu: unsigned quotient in LO, remainder in HI.
REQ-022 Divide by zero (B==0, div or divu): full DIV_CYCLES busy, HI/LO unchanged at completion.
REQ-023 div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
REQ-024 mthi/mtlo in IDLE with req low: HI/LO written with A at the edge, no busy.
REQ-025 Any MDUop while BUSY: ignored, no state change (stall unit prevents issue; block defends regardless).
REQ-026 req high: start forced 0, mthi/mtlo write suppressed; in-flight BUSY op continues to completion unaffected.
REQ-027 out reads current HI/LO registers, never hi_tmp/lo_tmp.

Reset
REQ-028 reset low, any time including mid-operation: HI=0, LO=0, hi_tmp=0, lo_tmp=0, cnt=0, state IDLE, busy=0 immediately.
REQ-029 First edge after reset release behaves as IDLE; start may be accepted on that edge.

Structure
REQ-030 MDUop encodings and MULT_CYCLES/DIV_CYCLES defaults belong in shared const.v.
REQ-031 Single module, no sub-module; arithmetic uses behavioural *, /, % operators.

Verification
REQ-032 mult A=0xFFFFFFFF B=0x00000002 -> busy 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE.
REQ-033 multu same operands -> HI=0x00000001 LO=0xFFFFFFFE after 5 busy cycles.
REQ-034 div A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; divu A=7 B=0 -> HI/LO unchanged.
REQ-035 mult with req=1 -> start=0, busy stays 0, HI/LO unchanged; mthi A=0x12345678 with req=1 -> HI unchanged, with req=0 -> HI=0x12345678 next cycle.
REQ-036 reset low at cycle 3 of a div -> busy=0, HI=LO=0 asynchronously; mflo next -> out=0.
